// File: rtl/array_pkg.sv
// Shared definitions for the refresh responder: FSM encoding and width/saturation constants.
package array_pkg;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_ACT,
        RESP_PRE
    } resp_state_t;

    localparam int ROW_NUM_DEFAULT = 8;
    localparam int CNT_SAT         = 255;

endpackage

// File: rtl/array_width_cnt.sv
// Saturating width counter: load forces the count to 1, inc advances it until CNT_SAT.
module array_width_cnt
    import array_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] SAT = CNT_WIDTH'(CNT_SAT);

    // NOTE: registers are written with <= so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_WIDTH'(1);
        end else if (inc && cnt != SAT) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/array_refresh_responder.sv
// Array-side refresh endpoint: times each activation and precharge, tracks the rows refreshed
// in the current sweep and flags timing, address-stability and range violations.
module array_refresh_responder
    import array_pkg::*;
#(
    parameter int ARRAY_ROW_ADDR_WIDTH = 16,
    parameter int ROW_NUM              = ROW_NUM_DEFAULT,
    parameter int CNT_WIDTH            = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            array_cs_n,
    input  logic [ARRAY_ROW_ADDR_WIDTH-1:0] array_raddr,
    input  logic [7:0]                      array_tRAS,
    input  logic [7:0]                      array_tRP,
    input  logic                            rf_clear,
    output logic [ROW_NUM-1:0]              rf_row_map,
    output logic                            rf_sweep_done,
    output logic                            tras_viol,
    output logic                            trp_viol,
    output logic                            addr_viol,
    output logic                            viol_sticky,
    output logic [15:0]                     act_cnt
);

    localparam int                 ROW_W    = $clog2(ROW_NUM);
    localparam logic [ROW_NUM-1:0] ALL_ROWS = '1;

    resp_state_t                     state;
    logic [ARRAY_ROW_ADDR_WIDTH-1:0] cap_addr;
    logic                            addr_mis;
    logic                            act_bad;
    logic [CNT_WIDTH-1:0]            low_cnt;
    logic [CNT_WIDTH-1:0]            high_cnt;

    logic act_start, act_end, low_inc, high_inc;
    logic tras_short, trp_short, addr_change, range_bad;
    logic row_ok, sweep_hit, new_viol, pulse_any;
    logic [ROW_W-1:0]   row_sel;
    logic [ROW_NUM-1:0] map_set;
    logic [ROW_NUM-1:0] map_next;

    assign act_start = !array_cs_n && (state != RESP_ACT);
    assign act_end   = array_cs_n && (state == RESP_ACT);
    assign low_inc   = !array_cs_n && (state == RESP_ACT);
    assign high_inc  = array_cs_n && (state == RESP_PRE);

    array_width_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_low_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (act_start),
        .inc  (low_inc),
        .cnt  (low_cnt)
    );

    array_width_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_high_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (act_end),
        .inc  (high_inc),
        .cnt  (high_cnt)
    );

    // A zero timing value disables its check; a start from IDLE has no precharge to measure.
    assign tras_short  = act_end && (array_tRAS != 8'd0) && (low_cnt < CNT_WIDTH'(array_tRAS));
    assign trp_short   = !array_cs_n && (state == RESP_PRE) && (array_tRP != 8'd0)
                         && (high_cnt < CNT_WIDTH'(array_tRP));
    assign addr_change = low_inc && (array_raddr != cap_addr) && !addr_mis;
    assign range_bad   = act_end && (cap_addr >= ARRAY_ROW_ADDR_WIDTH'(ROW_NUM));

    assign row_ok    = act_end && !(act_bad || addr_mis || tras_short || range_bad);
    assign row_sel   = cap_addr[ROW_W-1:0];
    assign map_set   = rf_row_map | (ROW_NUM'(1) << row_sel);
    assign sweep_hit = row_ok && (map_set == ALL_ROWS) && !rf_clear;
    assign new_viol  = tras_short || trp_short || addr_change || range_bad;
    assign pulse_any = tras_viol || trp_viol || addr_viol;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        map_next = rf_row_map;
        if (row_ok) begin
            map_next = map_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RESP_IDLE;
            cap_addr      <= '0;
            addr_mis      <= 1'b0;
            act_bad       <= 1'b0;
            rf_row_map    <= '0;
            rf_sweep_done <= 1'b0;
            tras_viol     <= 1'b0;
            trp_viol      <= 1'b0;
            addr_viol     <= 1'b0;
            viol_sticky   <= 1'b0;
            act_cnt       <= '0;
        end else begin
            tras_viol     <= tras_short;
            trp_viol      <= trp_short;
            addr_viol     <= addr_change || range_bad;
            rf_sweep_done <= sweep_hit;
            // A clear landing on a visible pulse must not erase that pulse from the sticky flag.
            viol_sticky   <= new_viol || (rf_clear ? pulse_any : viol_sticky);
            rf_row_map    <= (rf_clear || sweep_hit) ? '0 : map_next;
            if (act_end) begin
                act_cnt <= act_cnt + 16'd1;
            end

            case (state)
                RESP_IDLE: begin
                    if (!array_cs_n) begin
                        state    <= RESP_ACT;
                        cap_addr <= array_raddr;
                        addr_mis <= 1'b0;
                        act_bad  <= 1'b0;
                    end
                end
                RESP_ACT: begin
                    if (array_cs_n) begin
                        state <= RESP_PRE;
                    end else if (addr_change) begin
                        addr_mis <= 1'b1;
                    end
                end
                RESP_PRE: begin
                    if (!array_cs_n) begin
                        state    <= RESP_ACT;
                        cap_addr <= array_raddr;
                        addr_mis <= 1'b0;
                        act_bad  <= trp_short;
                    end
                end
                default: state <= RESP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_refresh_responder.sv
// Scoreboard bench: an activation-level model predicts every cycle's outputs; a monitor compares.
module tb_array_refresh_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        array_cs_n;
    logic [15:0] array_raddr;
    logic [7:0]  array_tRAS;
    logic [7:0]  array_tRP;
    logic        rf_clear;
    logic [7:0]  rf_row_map;
    logic        rf_sweep_done, tras_viol, trp_viol, addr_viol, viol_sticky;
    logic [15:0] act_cnt;

    array_refresh_responder dut (
        .clk           (clk),
        .rst           (rst),
        .array_cs_n    (array_cs_n),
        .array_raddr   (array_raddr),
        .array_tRAS    (array_tRAS),
        .array_tRP     (array_tRP),
        .rf_clear      (rf_clear),
        .rf_row_map    (rf_row_map),
        .rf_sweep_done (rf_sweep_done),
        .tras_viol     (tras_viol),
        .trp_viol      (trp_viol),
        .addr_viol     (addr_viol),
        .viol_sticky   (viol_sticky),
        .act_cnt       (act_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [7:0]  map;
        bit        sweep, tras, trp, addr, sticky;
        bit [15:0] acts;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_sweeps = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    endtask

    // Activation-level model: tracks run lengths of low/high phases as plain integers.
    bit        m_in_low, m_had_act, m_bad, m_mis, m_sticky, m_prev_any;
    int        m_low, m_high;
    bit [15:0] m_row, m_acts;
    bit [7:0]  m_map;

    always @(posedge clk) begin
        exp_t     e;
        bit       n_tras, n_trp, n_addr, n_sweep, any;
        bit [7:0] newmap;
        n_tras = 0; n_trp = 0; n_addr = 0; n_sweep = 0;
        if (rst) begin
            m_in_low = 0; m_had_act = 0; m_bad = 0; m_mis = 0; m_sticky = 0; m_prev_any = 0;
            m_low = 0; m_high = 0; m_row = 0; m_acts = 0; m_map = 0;
        end else begin
            newmap = m_map;
            if (!array_cs_n) begin
                if (!m_in_low) begin
                    m_bad = 0;
                    if (m_had_act && array_tRP != 0 && m_high < int'(array_tRP)) begin
                        n_trp = 1; m_bad = 1;
                    end
                    m_in_low = 1; m_low = 1; m_row = array_raddr; m_mis = 0;
                end else begin
                    m_low++;
                    if (array_raddr != m_row && !m_mis) begin
                        m_mis = 1; n_addr = 1;
                    end
                end
            end else if (m_in_low) begin
                m_in_low = 0; m_had_act = 1; m_high = 1; m_acts++;
                if (array_tRAS != 0 && m_low < int'(array_tRAS)) n_tras = 1;
                if (m_row >= 8) n_addr = 1;
                if (!(m_bad || m_mis || n_tras || n_addr)) newmap[m_row[2:0]] = 1'b1;
            end else begin
                m_high++;
            end
            if (rf_clear) m_map = 0;
            else if (newmap == 8'hFF) begin n_sweep = 1; m_map = 0; end
            else m_map = newmap;
            any        = n_tras || n_trp || n_addr;
            m_sticky   = any || (rf_clear ? m_prev_any : m_sticky);
            m_prev_any = any;
        end
        e.map = m_map; e.sweep = n_sweep; e.tras = n_tras; e.trp = n_trp; e.addr = n_addr;
        e.sticky = m_sticky; e.acts = m_acts;
        sb.push_back(e);
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("rf_row_map",    32'(rf_row_map),    32'(e.map));
            check("rf_sweep_done", 32'(rf_sweep_done), 32'(e.sweep));
            check("tras_viol",     32'(tras_viol),     32'(e.tras));
            check("trp_viol",      32'(trp_viol),      32'(e.trp));
            check("addr_viol",     32'(addr_viol),     32'(e.addr));
            check("viol_sticky",   32'(viol_sticky),   32'(e.sticky));
            check("act_cnt",       32'(act_cnt),       32'(e.acts));
            if (rf_sweep_done === 1'b1) n_sweeps++;
        end
    end

    task automatic cyc(input logic cs, input logic [15:0] a,
                       input logic clr = 1'b0, input logic r = 1'b0);
        array_cs_n  = cs;
        array_raddr = a;
        rf_clear    = clr;
        rst         = r;
        @(posedge clk);
        #2;
    endtask

    task automatic act(input logic [15:0] row, input int low, input int high);
        for (int i = 0; i < low; i++)  cyc(1'b0, row);
        for (int i = 0; i < high; i++) cyc(1'b1, row);
    endtask

    initial begin
        rst = 1'b1; array_cs_n = 1'b1; array_raddr = '0; rf_clear = 1'b0;
        array_tRAS = 8'd4; array_tRP = 8'd3;
        cyc(1'b1, 16'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'd0, 1'b0, 1'b1);

        // Legal sweep of all eight rows.
        for (int r = 0; r < 8; r++) act(16'(r), 4, 4);
        check("sweep act_cnt", 32'(act_cnt), 32'd8);
        check("sweep map", 32'(rf_row_map), 32'h0);
        check("sweep pulses", 32'(n_sweeps), 32'd1);
        check("sweep sticky", 32'(viol_sticky), 32'd0);

        // Short activation.
        array_tRAS = 8'd5;
        act(16'd2, 3, 4);
        check("tras sticky", 32'(viol_sticky), 32'd1);
        check("tras map2", 32'(rf_row_map[2]), 32'd0);

        // Short precharge between rows 1 and 2.
        array_tRAS = 8'd1; array_tRP = 8'd6;
        cyc(1'b1, 16'd0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'd0);
        act(16'd1, 2, 2);
        act(16'd2, 2, 8);
        check("trp map1", 32'(rf_row_map[1]), 32'd1);

        // Address instability and out-of-range row.
        array_tRP = 8'd0;
        cyc(1'b0, 16'd3); cyc(1'b0, 16'd3); cyc(1'b0, 16'd5); cyc(1'b0, 16'd5);
        cyc(1'b1, 16'd5); cyc(1'b1, 16'd5); cyc(1'b1, 16'd5);
        act(16'd9, 2, 3);
        check("addr map3", 32'(rf_row_map[3]), 32'd0);

        // Reset mid-activation, then a legal row 0.
        cyc(1'b0, 16'd1); cyc(1'b0, 16'd1);
        cyc(1'b0, 16'd1, 1'b0, 1'b1);
        check("rst sticky", 32'(viol_sticky), 32'd0);
        check("rst act_cnt", 32'(act_cnt), 32'd0);
        cyc(1'b1, 16'd0);
        act(16'd0, 1, 3);
        check("post-rst map", 32'(rf_row_map), 32'h01);

        // rf_clear against a visible violation pulse, then against a bitmap set.
        array_tRAS = 8'd5;
        cyc(1'b0, 16'd3); cyc(1'b0, 16'd3); cyc(1'b1, 16'd3);
        check("tras pulse", 32'(tras_viol), 32'd1);
        cyc(1'b1, 16'd3, 1'b1);
        check("clear vs viol sticky", 32'(viol_sticky), 32'd1);
        array_tRAS = 8'd1;
        cyc(1'b0, 16'd4); cyc(1'b0, 16'd4); cyc(1'b1, 16'd4, 1'b1);
        check("clear vs set map", 32'(rf_row_map), 32'h0);
        cyc(1'b1, 16'd4); cyc(1'b1, 16'd4);

        // Randomized activations with occasional glitches, clears and resets.
        for (int n = 0; n < 300; n++) begin
            int low, high, gpos;
            logic [15:0] row;
            bit glitch, do_rst;
            if (n % 20 == 0) begin
                array_tRAS = 8'($urandom_range(0, 5));
                array_tRP  = 8'($urandom_range(0, 5));
            end
            row    = 16'($urandom_range(0, 9));
            low    = $urandom_range(1, 6);
            high   = $urandom_range(1, 6);
            glitch = ($urandom_range(0, 7) == 0);
            gpos   = $urandom_range(1, 6);
            do_rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < low; i++)
                cyc(1'b0, (glitch && i == gpos) ? (row ^ 16'd1) : row,
                    1'($urandom_range(0, 15) == 0), do_rst && i == low - 1);
            for (int i = 0; i < high; i++)
                cyc(1'b1, row, 1'($urandom_range(0, 15) == 0));
        end

        cyc(1'b1, 16'd0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
